// File: rtl/mmio_timer_pkg.sv
// Shared register map, bit positions and byte-lane merge helper for mmio_timer.
package mmio_timer_pkg;

    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_COUNT   = 2'd1,
        REG_COMPARE = 2'd2,
        REG_STATUS  = 2'd3
    } reg_off_e;

    localparam int unsigned CTRL_EN           = 0;
    localparam int unsigned CTRL_AUTO_RELOAD  = 1;
    localparam int unsigned CTRL_IRQ_EN       = 2;
    localparam int unsigned CTRL_PRESCALE_LSB = 16;

    localparam int unsigned STATUS_MATCH = 0;
    localparam int unsigned STATUS_OVF   = 1;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] cur,
        input logic [31:0] wdata,
        input logic [3:0]  sel
    );
        logic [31:0] r;
        r = cur;
        for (int unsigned i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divide-by-(div+1) tick generator; frozen while disabled, restarted by clr.
module timer_prescaler #(
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pre_cnt;

    assign tick = en && (pre_cnt == div);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (clr) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= tick ? '0 : pre_cnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit timer: prescaled counter with compare match, overflow
// flag and level interrupt, combinational reads and edge-registered writes.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter int unsigned PRESCALE_W  = 16,
    parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        irq
);

    localparam logic [31:0] CTRL_MASK =
        32'h0000_0007 | (((32'd1 << PRESCALE_W) - 32'd1) << CTRL_PRESCALE_LSB);

    logic [31:0] ctrl_q;
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        match_q;
    logic        ovf_q;

    reg_off_e    off;
    logic        wr_any;
    logic        ctrl_wr;
    logic        count_wr;
    logic        compare_wr;
    logic        status_wr;
    logic        tick;
    logic [31:0] count_next;
    logic        match_set;
    logic        ovf_set;
    logic        unused_addr;

    assign unused_addr = ^{addr[31:4], addr[1:0]};

    always_comb begin
        off        = reg_off_e'(addr[3:2]);
        wr_any     = ce && we && (sel != 4'b0000);
        ctrl_wr    = wr_any && (off == REG_CTRL);
        count_wr   = wr_any && (off == REG_COUNT);
        compare_wr = wr_any && (off == REG_COMPARE);
        status_wr  = ce && we && (off == REG_STATUS) && sel[0];
    end

    timer_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (ctrl_q[CTRL_EN]),
        .clr  (ctrl_wr),
        .div  (ctrl_q[CTRL_PRESCALE_LSB +: PRESCALE_W]),
        .tick (tick)
    );

    // A bus write to COUNT suppresses the tick and all flag evaluation.
    always_comb begin
        count_next = count_q;
        match_set  = 1'b0;
        ovf_set    = 1'b0;
        if (count_wr) begin
            count_next = byte_merge(count_q, data_i, sel);
        end else if (tick) begin
            if (ctrl_q[CTRL_AUTO_RELOAD] && (count_q == compare_q)) begin
                count_next = '0;
            end else begin
                count_next = count_q + 32'd1;
                ovf_set    = (count_q == '1);
            end
            match_set = (count_next == compare_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= '0;
            count_q   <= '0;
            compare_q <= COMPARE_RST;
            match_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (ctrl_wr)    ctrl_q    <= byte_merge(ctrl_q, data_i, sel) & CTRL_MASK;
            if (compare_wr) compare_q <= byte_merge(compare_q, data_i, sel);
            count_q <= count_next;
            match_q <= match_set || (match_q && !(status_wr && data_i[STATUS_MATCH]));
            ovf_q   <= ovf_set   || (ovf_q   && !(status_wr && data_i[STATUS_OVF]));
        end
    end

    always_comb begin
        data_o = '0;
        if (ce && !we && !rst) begin
            case (off)
                REG_CTRL:    data_o = ctrl_q;
                REG_COUNT:   data_o = count_q;
                REG_COMPARE: data_o = compare_q;
                REG_STATUS: begin
                    data_o[STATUS_MATCH] = match_q;
                    data_o[STATUS_OVF]   = ovf_q;
                end
            endcase
        end
    end

    assign irq = ctrl_q[CTRL_IRQ_EN] && match_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed and randomized bench for mmio_timer against an arithmetic reference model.
module tb_mmio_timer;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        irq;

    int total = 0;
    int bad   = 0;

    longint unsigned m_ctrl, m_count, m_cmp;
    longint unsigned m_pre;
    bit              m_match, m_ovf;

    logic [31:0] last_rd;
    logic        last_irq;

    mmio_timer #(
        .PRESCALE_W (16),
        .COMPARE_RST(32'hFFFF_FFFF)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .we     (we),
        .addr   (addr),
        .sel    (sel),
        .data_i (data_i),
        .data_o (data_o),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    localparam longint unsigned TWO32 = 64'h1_0000_0000;

    function automatic longint unsigned mmerge(input longint unsigned cur,
                                               input logic [31:0] d,
                                               input logic [3:0] s);
        longint unsigned r;
        longint unsigned w;
        longint unsigned dv;
        r  = cur;
        dv = longint'(d);
        for (int i = 0; i < 4; i++) begin
            if (s[i]) begin
                w = 64'd1 << (8 * i);
                r = r - ((r / w) % 256) * w + ((dv / w) % 256) * w;
            end
        end
        return r;
    endfunction

    function automatic longint unsigned m_div();
        return m_ctrl / 65536;
    endfunction

    function automatic bit m_irq();
        return ((m_ctrl / 4) % 2 == 1) && m_match;
    endfunction

    task automatic model_reset();
        m_ctrl  = 0;
        m_count = 0;
        m_cmp   = 64'hFFFF_FFFF;
        m_pre   = 0;
        m_match = 0;
        m_ovf   = 0;
    endtask

    function automatic longint unsigned model_read(input bit r, input bit c, input bit w,
                                                   input logic [31:0] a);
        if (r || !c || w) return 0;
        case (a[3:2])
            2'd0:    return m_ctrl;
            2'd1:    return m_count;
            2'd2:    return m_cmp;
            default: return longint'(m_match) + 2 * longint'(m_ovf);
        endcase
    endfunction

    // One clock edge of the timer's rules applied to the pre-edge state.
    task automatic model_step(input bit r, input bit c, input bit w, input logic [31:0] a,
                              input logic [3:0] s, input logic [31:0] d);
        bit              en, tick, wr, clr, mset, oset;
        longint unsigned cnt_n, pre_n;
        int              rg;
        if (r) begin
            model_reset();
            return;
        end
        en    = (m_ctrl % 2 == 1);
        tick  = en && (m_pre == m_div());
        wr    = c && w && (s != 4'b0000);
        rg    = int'(a[3:2]);
        clr   = c && w && (rg == 3) && s[0];
        mset  = 0;
        oset  = 0;
        cnt_n = m_count;
        pre_n = m_pre;
        if (wr && rg == 0)  pre_n = 0;
        else if (en)        pre_n = tick ? 0 : m_pre + 1;
        if (wr && rg == 1) begin
            cnt_n = mmerge(m_count, d, s);
        end else if (tick) begin
            if (((m_ctrl / 2) % 2 == 1) && m_count == m_cmp) begin
                cnt_n = 0;
            end else begin
                cnt_n = (m_count + 1) % TWO32;
                oset  = (cnt_n == 0);
            end
            mset = (cnt_n == m_cmp);
        end
        m_match = mset || (m_match && !(clr && d[0]));
        m_ovf   = oset || (m_ovf && !(clr && d[1]));
        if (wr && rg == 0) begin
            m_ctrl = mmerge(m_ctrl, d, s);
            m_ctrl = (m_ctrl % 8) + (m_ctrl / 65536) * 65536;
        end
        if (wr && rg == 2) m_cmp = mmerge(m_cmp, d, s);
        m_count = cnt_n;
        m_pre   = pre_n;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic bus(input bit c, input bit w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
        ce     = c;
        we     = w;
        addr   = a;
        sel    = s;
        data_i = d;
        @(negedge clk);
        last_rd  = data_o;
        last_irq = irq;
        check("data_o", data_o, 32'(model_read(rst, c, w, a)));
        check("irq", {31'b0, irq}, {31'b0, m_irq()});
        @(posedge clk);
        model_step(rst, c, w, a, s, d);
        #1;
    endtask

    task automatic rd(input logic [31:0] a);
        bus(1'b1, 1'b0, a, 4'b0000, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus(1'b1, 1'b1, a, s, d);
    endtask

    logic [31:0] seq [24];
    logic        irqs [24];
    int          n;
    int          op;
    int          rg;
    logic [31:0] a, d;
    logic [3:0]  s;

    initial begin
        model_reset();
        rst = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; sel = '0; data_i = '0;
        bus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        bus(1'b1, 1'b1, 32'h4, 4'hF, 32'hDEAD_BEEF);
        rst = 1'b0;

        // reset values
        rd(32'h0);  check("rst_ctrl", last_rd, 32'h0);
        rd(32'h4);  check("rst_count", last_rd, 32'h0);
        rd(32'h8);  check("rst_compare", last_rd, 32'hFFFF_FFFF);
        rd(32'hC);  check("rst_status", last_rd, 32'h0);
        check("rst_irq", {31'b0, last_irq}, 32'h0);
        bus(1'b0, 1'b0, 32'h8, 4'h0, 32'h0);
        check("idle_data_o", last_rd, 32'h0);

        // prescale 0 free-run
        wr(32'h0, 32'h0000_0001, 4'hF);
        rd(32'h4); check("run_c1", last_rd, 32'd0);
        rd(32'h4); check("run_c2", last_rd, 32'd1);
        rd(32'h4); check("run_c3", last_rd, 32'd2);
        rd(32'h4); check("run_c4", last_rd, 32'd3);
        wr(32'h0, 32'h0, 4'hF);
        rd(32'h4); check("hold_a", last_rd, 32'd5);
        rd(32'h4); check("hold_b", last_rd, 32'd5);

        // prescale 3, auto-reload, compare 4
        wr(32'h4, 32'h0, 4'hF);
        wr(32'h8, 32'd4, 4'hF);
        wr(32'hC, 32'h3, 4'hF);
        wr(32'h0, 32'h0003_0007, 4'hF);
        for (int k = 0; k < 24; k++) begin
            rd(32'h4);
            seq[k]  = last_rd;
            irqs[k] = last_irq;
        end
        check("ar_k3",  seq[3],  32'd0);
        check("ar_k4",  seq[4],  32'd1);
        check("ar_k8",  seq[8],  32'd2);
        check("ar_k12", seq[12], 32'd3);
        check("ar_k16", seq[16], 32'd4);
        check("ar_k20", seq[20], 32'd0);
        check("ar_irq_before", {31'b0, irqs[15]}, 32'd0);
        check("ar_irq_at", {31'b0, irqs[16]}, 32'd1);
        check("ar_irq_held", {31'b0, irqs[20]}, 32'd1);
        wr(32'hC, 32'h1, 4'h1);
        rd(32'hC);
        check("w1c_status", last_rd & 32'h1, 32'h0);
        check("w1c_irq", {31'b0, last_irq}, 32'd0);

        // W1C on the same edge MATCH re-sets
        n = 0;
        while (!(m_count == 3 && m_pre == m_div()) && n < 40) begin
            rd(32'h4);
            n++;
        end
        check("collide_wait", {31'b0, n < 40}, 32'd1);
        wr(32'hC, 32'h1, 4'h1);
        rd(32'hC);
        check("match_beats_w1c", last_rd & 32'h1, 32'h1);

        // 32-bit wrap and OVF
        wr(32'h0, 32'h0, 4'hF);
        wr(32'h4, 32'hFFFF_FFFE, 4'hF);
        wr(32'hC, 32'h3, 4'hF);
        wr(32'h0, 32'h1, 4'hF);
        rd(32'h4); check("wrap_a", last_rd, 32'hFFFF_FFFE);
        rd(32'h4); check("wrap_b", last_rd, 32'hFFFF_FFFF);
        rd(32'h4); check("wrap_c", last_rd, 32'h0);
        wr(32'h0, 32'h0, 4'hF);
        rd(32'hC); check("ovf_set", last_rd, 32'h2);
        wr(32'hC, 32'h2, 4'h0);
        rd(32'hC); check("ovf_sel0", last_rd, 32'h2);
        wr(32'hC, 32'h2, 4'h1);
        rd(32'hC); check("ovf_clr", last_rd, 32'h0);

        // byte lanes
        wr(32'h8, 32'hFFFF_FFFF, 4'hF);
        wr(32'h8, 32'h1234_5678, 4'b0101);
        rd(32'h8); check("byte_mask", last_rd, 32'hFF34_FF78);

        // COUNT write on a tick cycle
        wr(32'h0, 32'h1, 4'hF);
        wr(32'h4, 32'h100, 4'hF);
        rd(32'h4); check("count_wr_wins", last_rd, 32'h100);

        // reset mid-count
        rst = 1'b1;
        bus(1'b1, 1'b1, 32'h8, 4'hF, 32'h5555_5555);
        rst = 1'b0;
        rd(32'h0); check("mid_rst_ctrl", last_rd, 32'h0);
        rd(32'h4); check("mid_rst_count", last_rd, 32'h0);
        rd(32'h8); check("mid_rst_compare", last_rd, 32'hFFFF_FFFF);
        rd(32'hC); check("mid_rst_status", last_rd, 32'h0);

        // randomized traffic against the model
        wr(32'h0, 32'h0001_0007, 4'hF);
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            op  = int'($urandom_range(0, 9));
            rg  = int'($urandom_range(0, 3));
            a   = ($urandom & 32'hFFFF_FFF3) | (32'(rg) << 2);
            s   = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            d   = $urandom;
            case (rg)
                0: d[31:16] = 16'($urandom_range(0, 3));
                1: d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                   : 32'($urandom_range(0, 12));
                2: d = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 12));
                default: ;
            endcase
            if (op <= 4)      bus(1'b1, 1'b0, a, s, d);
            else if (op <= 7) bus(1'b1, 1'b1, a, s, d);
            else              bus(1'b0, 1'($urandom_range(0, 1)), a, s, d);
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped 32-bit timer/counter that answers the CPU's data-bus accesses (ce/we/addr/sel/data) as a responder alongside the data RAM. The address decoder in the SOPC top asserts `ce` only for this block's window. The block provides a programmable prescaler, a free-running or auto-reloading counter, a compare match, an overflow flag and a level interrupt to the CPU. Reads are combinational, like the data RAM; writes take effect on the clock edge.

## Interface
- `PRESCALE_W`, 16: width of the prescaler divisor field and internal prescale counter (max 16).
- `COMPARE_RST`, 32'hFFFF_FFFF: reset value of COMPARE.

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `ce`  in  1  access strobe from CPU data port.
- `we`  in  1  1 = write, 0 = read; valid only with `ce`.
- `addr`  in  32  byte address; only `addr[3:2]` decoded.
- `sel`  in  4  byte enables for writes; `sel[i]` enables `data_i[8i+7:8i]`.
- `data_i`  in  32  write data.
- `data_o`  out  32  read data.
- `irq`  out  1  level interrupt.

## Operation
- Register map (`addr[3:2]`):
  - 0 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, `[16+PRESCALE_W-1:16]` PRESCALE (divide-by PRESCALE+1). Other bits read 0.
  - 1 COUNT: read/write.
  - 2 COMPARE: read/write.
  - 3 STATUS: bit0 MATCH, bit1 OVF. Both bits are sticky and write-1-to-clear via `sel[0]`. Other bits read 0.
- Reset values: CTRL=0, COUNT=0, COMPARE=`COMPARE_RST`, STATUS=0, prescale counter=0, `irq`=0, `data_o`=0.
- Writes (`ce & we`): byte-masked by `sel`. `sel`=0 writes nothing.
- Reads (`ce & ~we`): `data_o` = addressed register. Otherwise `data_o`=0.
- Prescaler (when EN=1):
  - If pre_cnt==PRESCALE: pre_cnt←0 and tick.
  - Otherwise pre_cnt increments.
  - EN=0 freezes pre_cnt and COUNT.
  - Any CTRL write clears pre_cnt.
- On tick:
  - If AUTO_RELOAD and COUNT==COMPARE: COUNT←0.
  - Else COUNT←COUNT+1, mod 2^32. A wrap from 0xFFFF_FFFF to 0 sets OVF.
  - If the next COUNT equals COMPARE, MATCH is set.
  - With auto-reload, the period is COMPARE+1 ticks and MATCH sets on entry to COMPARE.
- `irq` = IRQ_EN & MATCH, driven from registered state with no combinational path from the bus.
- Simultaneous events:
  - A CPU write to COUNT beats a same-cycle tick. The written value is loaded, no increment occurs, and no MATCH or OVF is evaluated that cycle. pre_cnt is unaffected.
  - A hardware set of MATCH/OVF beats a same-cycle W1C clear.
  - A COMPARE write applies to match evaluation from the next cycle.
- `rst` asserted mid-operation returns all state to reset values at that edge. Bus accesses during `rst` are ignored.

## Timing
- Read latency 0: `data_o` is valid in the same cycle as `ce & ~we`.
- Write latency: the register updates on the rising edge where `ce & we` is sampled. The value is readable the next cycle.
- With PRESCALE=0, the first tick occurs at the first edge after EN reads 1, so COUNT reads 1 one cycle after the EN write edge. Thereafter COUNT increments every cycle.
- With PRESCALE=N, ticks occur every N+1 cycles. The first tick comes N+1 edges after the CTRL write edge.
- MATCH/OVF are visible, and `irq` rises, in the cycle after the tick edge that produced them.
- A W1C clear drops `irq` one cycle after the write edge.

## Structure
- Shared package `mmio_timer_pkg` holds:
  - register offsets (CTRL=2'd0, COUNT=2'd1, COMPARE=2'd2, STATUS=2'd3);
  - CTRL bit positions (EN=0, AUTO_RELOAD=1, IRQ_EN=2, PRESCALE_LSB=16);
  - STATUS bit positions (MATCH=0, OVF=1).
- One sub-module, `timer_prescaler`: inputs `clk`, `rst`, `en`, `clr`, `div[PRESCALE_W-1:0]`; output `tick`.
- Register file, bus decode and counter logic live in `mmio_timer`.

## Test plan
- Reset then read all four offsets → 0, 0, 0xFFFF_FFFF, 0. `irq`=0. Read with `ce`=0 → `data_o`=0.
- Write CTRL=0x0000_0001 (PRESCALE 0) → COUNT reads 1, 2, 3 on successive cycles. Write CTRL=0 → COUNT holds.
- CTRL=0x0003_0007 (PRESCALE 3, auto-reload, IRQ_EN), COMPARE=4 → COUNT steps every 4 cycles 0→1→2→3→4→0. MATCH and `irq` assert the cycle after COUNT becomes 4. Writing STATUS=1 clears `irq` one cycle later.
- COUNT=0xFFFF_FFFE, CTRL=1 → COUNT 0xFFFF_FFFF then 0. STATUS reads 0x2 after the wrap. Writing STATUS=2 with `sel`=4'b0000 leaves OVF set; with `sel`=4'b0001 it clears.
- Byte-masked write: COMPARE=0xFFFF_FFFF, write 0x1234_5678 with `sel`=4'b0101 → COMPARE reads 0xFF34_FF78.
- Collisions:
  - COUNT write of 0x100 on a tick cycle → reads 0x100, not 0x101.
  - W1C of MATCH on the cycle MATCH re-sets → MATCH stays 1.
  - Assert `rst` mid-count → all registers return to reset values next cycle.
